// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXECUTE(/MEM) sequencing with a bus timeout.
// Define ILLEGAL_TRAP_EN to halt on unknown opcodes; otherwise they execute as a NOP.
module multicycle_control_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instrCode,
  input  logic        busReady,
  output logic        pcEn,
  output logic        regFileWe,
  output logic [3:0]  aluControl,
  output logic        aluSrcMuxSel,
  output logic [2:0]  RFWDSrcMuxSel,
  output logic        branch,
  output logic        jal,
  output logic        jalr,
  output logic        busReq,
  output logic        busWe,
  output logic        busError,
  output logic        illegalInstr
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_B  = 7'b1100011;
  localparam logic [6:0] OP_LU = 7'b0110111;
  localparam logic [6:0] OP_AU = 7'b0010111;
  localparam logic [6:0] OP_J  = 7'b1101111;
  localparam logic [6:0] OP_JL = 7'b1100111;
  localparam logic [6:0] OP_L  = 7'b0000011;
  localparam logic [6:0] OP_S  = 7'b0100011;

  localparam logic [3:0] ALU_ADD = 4'b0000;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_HALT
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic       is_store;
  logic       timeout_hit;
  logic       unused_instr_bits;

  assign opcode            = instrCode[6:0];
  assign funct3            = instrCode[14:12];
  assign funct7_b5         = instrCode[30];
  assign is_store          = (opcode == OP_S);
  assign timeout_hit       = (TIMEOUT_CYCLES != 0) && (32'(cnt_q) == TIMEOUT_CYCLES - 1);
  assign unused_instr_bits = ^{instrCode[31], instrCode[29:15], instrCode[11:7]};

  // State and MEM wait counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and datapath controls; the load write-back must see busReady in the same cycle
  always_comb begin
    state_d       = state_q;
    cnt_d         = '0;
    pcEn          = 1'b0;
    regFileWe     = 1'b0;
    aluControl    = ALU_ADD;
    aluSrcMuxSel  = 1'b0;
    RFWDSrcMuxSel = 3'd0;
    branch        = 1'b0;
    jal           = 1'b0;
    jalr          = 1'b0;
    busReq        = 1'b0;
    busWe         = 1'b0;
    busError      = 1'b0;
    illegalInstr  = 1'b0;

    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXECUTE;
      S_EXECUTE: begin
        state_d = S_FETCH;
        case (opcode)
          OP_R: begin
            regFileWe  = 1'b1;
            aluControl = {funct7_b5, funct3};
            pcEn       = 1'b1;
          end
          OP_I: begin
            regFileWe    = 1'b1;
            aluSrcMuxSel = 1'b1;
            aluControl   = {(funct3 == 3'b101) ? funct7_b5 : 1'b0, funct3};
            pcEn         = 1'b1;
          end
          OP_B: begin
            branch     = 1'b1;
            aluControl = {1'b0, funct3};
            pcEn       = 1'b1;
          end
          OP_LU: begin
            RFWDSrcMuxSel = 3'd2;
            regFileWe     = 1'b1;
            pcEn          = 1'b1;
          end
          OP_AU: begin
            RFWDSrcMuxSel = 3'd3;
            regFileWe     = 1'b1;
            pcEn          = 1'b1;
          end
          OP_J: begin
            jal           = 1'b1;
            RFWDSrcMuxSel = 3'd4;
            regFileWe     = 1'b1;
            pcEn          = 1'b1;
          end
          OP_JL: begin
            jal           = 1'b1;
            jalr          = 1'b1;
            RFWDSrcMuxSel = 3'd4;
            regFileWe     = 1'b1;
            pcEn          = 1'b1;
          end
          OP_L, OP_S: begin
            aluSrcMuxSel = 1'b1;
            state_d      = S_MEM;
          end
          default: begin
            illegalInstr = 1'b1;
`ifdef ILLEGAL_TRAP_EN
            state_d      = S_HALT;
`else
            pcEn         = 1'b1;
`endif
          end
        endcase
      end
      S_MEM: begin
        // Address/data path held on rs1+imm for the whole transaction
        busReq       = 1'b1;
        busWe        = is_store;
        aluSrcMuxSel = 1'b1;
        if (!is_store) RFWDSrcMuxSel = 3'd1;
        if (busReady) begin
          regFileWe = !is_store;
          pcEn      = 1'b1;
          state_d   = S_FETCH;
        end else if (timeout_hit) begin
          busError = 1'b1;
          pcEn     = 1'b1;
          state_d  = S_FETCH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HALT:  illegalInstr = 1'b1;
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized self-checking bench for multicycle_control_unit against a per-phase instruction model.
module tb_multicycle_control_unit;

  localparam int unsigned TO = 4;

  typedef struct packed {
    logic       pc_en;
    logic       rf_we;
    logic [3:0] alu;
    logic       src;
    logic [2:0] rfwd;
    logic       br;
    logic       jal;
    logic       jalr;
    logic       req;
    logic       we;
    logic       err;
    logic       ill;
  } ctl_t;

  logic        clk;
  logic        reset;
  logic [31:0] instrCode;
  logic        busReady;
  logic        pcEn, regFileWe, aluSrcMuxSel, branch, jal, jalr;
  logic        busReq, busWe, busError, illegalInstr;
  logic [3:0]  aluControl;
  logic [2:0]  RFWDSrcMuxSel;
  ctl_t        act;

  int n_tests = 0;
  int n_fail  = 0;

  multicycle_control_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .instrCode    (instrCode),
    .busReady     (busReady),
    .pcEn         (pcEn),
    .regFileWe    (regFileWe),
    .aluControl   (aluControl),
    .aluSrcMuxSel (aluSrcMuxSel),
    .RFWDSrcMuxSel(RFWDSrcMuxSel),
    .branch       (branch),
    .jal          (jal),
    .jalr         (jalr),
    .busReq       (busReq),
    .busWe        (busWe),
    .busError     (busError),
    .illegalInstr (illegalInstr)
  );

  assign act = {pcEn, regFileWe, aluControl, aluSrcMuxSel, RFWDSrcMuxSel,
                branch, jal, jalr, busReq, busWe, busError, illegalInstr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input ctl_t got, input ctl_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (instr %h)", tag, got, exp, instrCode);
    end
  endtask

  // Controls expected in the third cycle of an instruction, straight from the opcode table
  function automatic ctl_t exp_exec(input logic [31:0] ins);
    ctl_t       e;
    logic [2:0] f3;
    f3 = ins[14:12];
    e  = '0;
    case (ins[6:0])
      7'b0110011: begin e.rf_we = 1; e.alu = {ins[30], f3}; e.pc_en = 1; end
      7'b0010011: begin
        e.rf_we = 1; e.src = 1; e.pc_en = 1;
        e.alu = {(f3 == 3'b101) ? ins[30] : 1'b0, f3};
      end
      7'b1100011: begin e.br = 1; e.alu = {1'b0, f3}; e.pc_en = 1; end
      7'b0110111: begin e.rfwd = 3'd2; e.rf_we = 1; e.pc_en = 1; end
      7'b0010111: begin e.rfwd = 3'd3; e.rf_we = 1; e.pc_en = 1; end
      7'b1101111: begin e.jal = 1; e.rfwd = 3'd4; e.rf_we = 1; e.pc_en = 1; end
      7'b1100111: begin e.jal = 1; e.jalr = 1; e.rfwd = 3'd4; e.rf_we = 1; e.pc_en = 1; end
      7'b0000011, 7'b0100011: e.src = 1;
      default: begin
        e.ill = 1;
`ifndef ILLEGAL_TRAP_EN
        e.pc_en = 1;
`endif
      end
    endcase
    return e;
  endfunction

  // One clock per call: drive inputs on the falling edge, settle, then compare
  task automatic step(input logic [31:0] ins, input logic rdy);
    @(negedge clk);
    instrCode = ins;
    busReady  = rdy;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("reset", act, ctl_t'(0));
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  // waits: wait cycles before busReady (>= TO means timeout); rst_at: MEM cycle to reset in, -1 none
  task automatic run_instr(input logic [31:0] ins, input int waits, input int rst_at);
    ctl_t e;
    logic is_mem, is_s, rdy, tmo;
    is_mem = (ins[6:0] == 7'b0000011) || (ins[6:0] == 7'b0100011);
    is_s   = (ins[6:0] == 7'b0100011);
    step(ins, 1'($urandom));
    check("fetch", act, ctl_t'(0));
    step(ins, 1'($urandom));
    check("decode", act, ctl_t'(0));
    step(ins, 1'($urandom));
    check("execute", act, exp_exec(ins));
    if (is_mem) begin
      for (int k = 0; k < int'(TO); k++) begin
        rdy = (k == waits);
        step(ins, rdy);
        if (k == rst_at) begin
          do_reset();
          return;
        end
        tmo     = !rdy && (k == int'(TO) - 1);
        e       = '0;
        e.req   = 1;
        e.we    = is_s;
        e.src   = 1;
        e.rfwd  = is_s ? 3'd0 : 3'd1;
        e.rf_we = !is_s && rdy;
        e.pc_en = rdy || tmo;
        e.err   = tmo;
        check(tmo ? "mem_timeout" : (rdy ? "mem_ready" : "mem_wait"), act, e);
        if (rdy || tmo) break;
      end
    end
  endtask

  function automatic logic [31:0] rand_instr(input int cls);
    logic [31:0] ins;
    logic [6:0]  ops [0:8];
    logic [6:0]  bad [0:2];
    ops = '{7'b0110011, 7'b0010011, 7'b1100011, 7'b0110111, 7'b0010111,
            7'b1101111, 7'b1100111, 7'b0000011, 7'b0100011};
    bad = '{7'h7F, 7'h73, 7'h0F};
    ins = $urandom;
    ins[6:0] = (cls < 9) ? ops[cls] : bad[$urandom_range(0, 2)];
    return ins;
  endfunction

  initial begin
    int          cls, waits, rst_at, max_cls;
    logic [31:0] ins;
    reset     = 1'b1;
    instrCode = 32'h0000_0013;
    busReady  = 1'b0;
    @(negedge clk);
    do_reset();

    run_instr(32'h002081B3, 0, -1);   // add x3,x1,x2
    run_instr(32'h0020A423, 2, -1);   // sw, two wait cycles
    run_instr(32'h0040A283, 0, -1);   // lw, immediate ready
    run_instr(32'h00208463, 0, -1);   // beq
    run_instr(32'h000000E7, 0, -1);   // jalr
    run_instr(32'h0040A283, 10, -1);  // lw, bus timeout
    run_instr(32'h0040A283, 10, 1);   // lw, reset in second MEM cycle
    run_instr(32'h0040A283, int'(TO) - 1, -1);  // ready on the timeout cycle wins

`ifdef ILLEGAL_TRAP_EN
    max_cls = 8;
`else
    max_cls = 9;
`endif
    for (int n = 0; n < 80; n++) begin
      cls    = $urandom_range(0, max_cls);
      ins    = rand_instr(cls);
      waits  = $urandom_range(0, 5);
      rst_at = -1;
      if ($urandom_range(0, 9) == 0)
        rst_at = $urandom_range(0, (waits < int'(TO) - 1) ? waits : int'(TO) - 1);
      run_instr(ins, waits, rst_at);
    end

    run_instr(32'h0000007F, 0, -1);
`ifdef ILLEGAL_TRAP_EN
    for (int h = 0; h < 6; h++) begin
      step(32'h002081B3, 1'($urandom));
      check("halt", act, ctl_t'(17'h1));
    end
    @(negedge clk);
    do_reset();
`endif
    run_instr(32'h002081B3, 0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
